// File: rtl/spec_pair_judge_pkg.sv
// Shared types and constants for the speculative pair judge.
// State encoding, conflict_cause bit positions and default serial mask.
package spec_pair_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam int CAUSE_RES = 0;
   localparam int CAUSE_SER = 1;
   localparam int CAUSE_DEP = 2;

   localparam logic [31:0] DEF_SERIAL_MASK = 32'h0000_0FE0;

endpackage

// File: rtl/spec_pair_judge_hazard.sv
// Combinational hazard judge for a normal/speculative issue pair.
// SPEC_PAIR_WAW_CHECK_EN adds dest==dest to the dependency check.
module spec_pair_hazard
   import spec_pair_pkg::*;
#(
   parameter int                 UCODE_W     = 32,
   parameter int                 INSTR_W     = 32,
   parameter int                 REG_W       = 8,
   parameter logic [UCODE_W-1:0] SERIAL_MASK = DEF_SERIAL_MASK
) (
   input  logic [UCODE_W-1:0] micro_code_normal,
   input  logic [UCODE_W-1:0] micro_code_speculative,
   input  logic [INSTR_W-1:0] instruction_normal,
   input  logic [INSTR_W-1:0] instruction_speculative,
   output logic               resource,
   output logic               serial,
   output logic               dep
);

   logic [REG_W-1:0] n_dest;
   logic [REG_W-1:0] s_src1;
   logic [REG_W-1:0] s_src2;
   logic             waw;
   logic             unused_instr;

   assign n_dest = instruction_normal[REG_W-1:0];
   assign s_src2 = instruction_speculative[2*REG_W-1:REG_W];
   assign s_src1 = instruction_speculative[3*REG_W-1:2*REG_W];

   // Upper instruction bits carry no register fields.
   assign unused_instr = ^{instruction_normal, instruction_speculative};

`ifdef SPEC_PAIR_WAW_CHECK_EN
   logic [REG_W-1:0] s_dest;
   assign s_dest = instruction_speculative[REG_W-1:0];
   assign waw    = (s_dest == n_dest);
`else
   assign waw    = 1'b0;
`endif

   // Resource overlap, serializing ops and RAW (optionally WAW) hazards.
   always_comb begin
      resource = |(micro_code_normal & micro_code_speculative);
      serial   = |(micro_code_normal & SERIAL_MASK);
      dep      = (s_src1 == n_dest) || (s_src2 == n_dest) || waw;
   end

endmodule

// File: rtl/spec_pair_judge.sv
// Dual-issue pair judge: registered verdict with one-deep skid and a
// multi-cycle HOLD tracker. Optional SPEC_PAIR_WAW_CHECK_EN (see hazard).
module spec_pair_judge
   import spec_pair_pkg::*;
#(
   parameter int                 UCODE_W     = 32,
   parameter int                 INSTR_W     = 32,
   parameter int                 REG_W       = 8,
   parameter logic [UCODE_W-1:0] SERIAL_MASK = DEF_SERIAL_MASK,
   parameter int                 CNT_W       = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [UCODE_W-1:0] micro_code_normal,
   input  logic [UCODE_W-1:0] micro_code_speculative,
   input  logic [INSTR_W-1:0] instruction_normal,
   input  logic [INSTR_W-1:0] instruction_speculative,
   input  logic [CNT_W-1:0]   micro_instruction_cnt_speculative,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               pair_ok,
   output logic [2:0]         conflict_cause,
   output logic               busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             pair_ok_q, pair_ok_d;
   logic [2:0]       cause_q, cause_d;

   logic             resource;
   logic             serial;
   logic             dep;
   logic             accept;
   logic             judge_ok;

   spec_pair_hazard #(
      .UCODE_W     (UCODE_W),
      .INSTR_W     (INSTR_W),
      .REG_W       (REG_W),
      .SERIAL_MASK (SERIAL_MASK)
   ) u_hazard (
      .micro_code_normal       (micro_code_normal),
      .micro_code_speculative  (micro_code_speculative),
      .instruction_normal      (instruction_normal),
      .instruction_speculative (instruction_speculative),
      .resource                (resource),
      .serial                  (serial),
      .dep                     (dep)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // A pair in HOLD (including the final HOLD cycle) is never dual-issued.
   assign judge_ok = (state_q == IDLE) && !resource && !serial && !dep;

   // Next-state for the HOLD tracker and the verdict register.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      out_valid_d = out_valid_q;
      pair_ok_d   = pair_ok_q;
      cause_d     = cause_q;

      unique case (state_q)
         IDLE: begin
            if (accept && judge_ok &&
                (micro_instruction_cnt_speculative != '0)) begin
               state_d    = HOLD;
               hold_cnt_d = micro_instruction_cnt_speculative;
            end
         end
         HOLD: begin
            if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
            if (hold_cnt_q <= CNT_W'(1)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         out_valid_d = 1'b1;
         pair_ok_d   = judge_ok;
         cause_d     = 3'b000;
         if (state_q == IDLE) begin
            cause_d[CAUSE_RES] = resource;
            cause_d[CAUSE_SER] = serial;
            cause_d[CAUSE_DEP] = dep;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State and verdict registers; reset drops any pending work.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         hold_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         pair_ok_q   <= 1'b0;
         cause_q     <= 3'b000;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         out_valid_q <= out_valid_d;
         pair_ok_q   <= pair_ok_d;
         cause_q     <= cause_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign pair_ok        = pair_ok_q;
   assign conflict_cause = cause_q;
   assign busy           = (state_q == HOLD);

endmodule

// File: tb/tb_spec_pair_judge.sv
// Self-checking bench for spec_pair_judge.
// Scoreboard of {pair_ok, cause} pushed at drive, popped at verdict.
module tb_spec_pair_judge;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] micro_code_normal;
   logic [31:0] micro_code_speculative;
   logic [31:0] instruction_normal;
   logic [31:0] instruction_speculative;
   logic [2:0]  micro_instruction_cnt_speculative;
   logic        out_valid;
   logic        out_ready;
   logic        pair_ok;
   logic [2:0]  conflict_cause;
   logic        busy;

   int          checks   = 0;
   int          failures = 0;
   logic [3:0]  exp_q[$];

   spec_pair_judge dut (
      .clk                               (clk),
      .rst                               (rst),
      .in_valid                          (in_valid),
      .in_ready                          (in_ready),
      .micro_code_normal                 (micro_code_normal),
      .micro_code_speculative            (micro_code_speculative),
      .instruction_normal                (instruction_normal),
      .instruction_speculative           (instruction_speculative),
      .micro_instruction_cnt_speculative (micro_instruction_cnt_speculative),
      .out_valid                         (out_valid),
      .out_ready                         (out_ready),
      .pair_ok                           (pair_ok),
      .conflict_cause                    (conflict_cause),
      .busy                              (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] ins(input logic [7:0] s1,
                                       input logic [7:0] s2,
                                       input logic [7:0] d);
      return {8'h00, s1, s2, d};
   endfunction

   // Reference judge for an IDLE block: {pair_ok, dep, serial, resource}.
   function automatic logic [3:0] model(input logic [31:0] ucn,
                                        input logic [31:0] ucs,
                                        input logic [31:0] in_n,
                                        input logic [31:0] in_s);
      logic r, s, d;
      r = (ucn & ucs) != 32'h0;
      s = (ucn & 32'h0000_0FE0) != 32'h0;
      d = (in_s[23:16] == in_n[7:0]) || (in_s[15:8] == in_n[7:0]);
`ifdef SPEC_PAIR_WAW_CHECK_EN
      d = d || (in_s[7:0] == in_n[7:0]);
`endif
      return {!(r || s || d), d, s, r};
   endfunction

   task automatic drive(input logic [31:0] ucn, input logic [31:0] ucs,
                        input logic [31:0] in_n, input logic [31:0] in_s,
                        input logic [2:0] cnt);
      micro_code_normal                 = ucn;
      micro_code_speculative            = ucs;
      instruction_normal                = in_n;
      instruction_speculative           = in_s;
      micro_instruction_cnt_speculative = cnt;
      in_valid                          = 1'b1;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive(32'h0, 32'h0, 32'h0, 32'h0, 3'd0);
      in_valid = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (pair_ok !== 1'b0) begin
         failures++;
         $display("FAIL reset_pair_ok got=%b exp=0", pair_ok);
      end
      checks++;
      if (conflict_cause !== 3'b000) begin
         failures++;
         $display("FAIL reset_cause got=%b exp=000", conflict_cause);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [31:0] ucn[4];
      logic [31:0] ucs[4];
      logic [31:0] isp[4];
      logic [3:0]  exv[4];
      logic [3:0]  e;
      ucn = '{32'h1, 32'h4, 32'h20, 32'h1};
      ucs = '{32'h2, 32'h4, 32'h2, 32'h2};
      isp = '{ins(8'h01, 8'h02, 8'h07), ins(8'h01, 8'h02, 8'h07),
              ins(8'h01, 8'h02, 8'h07), ins(8'h05, 8'h02, 8'h07)};
      exv = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(ucn[i], ucs[i], ins(8'h33, 8'h44, 8'h05), isp[i], 3'd0);
         exp_q.push_back(exv[i]);
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic%0d_valid got=%b exp=1", i, out_valid);
         end
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
         checks++;
         if ({pair_ok, conflict_cause} !== e) begin
            failures++;
            $display("FAIL basic%0d_verdict got=%b exp=%b", i,
                     {pair_ok, conflict_cause}, e);
         end
      end
   endtask

   task automatic test_waw;
      logic [3:0] e;
      @(negedge clk);
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h05), 3'd0);
`ifdef SPEC_PAIR_WAW_CHECK_EN
      exp_q.push_back(4'b0100);
`else
      exp_q.push_back(4'b1000);
`endif
      @(negedge clk);
      in_valid = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if (!out_valid || {pair_ok, conflict_cause} !== e) begin
         failures++;
         $display("FAIL waw got=%b/%b exp=1/%b", out_valid,
                  {pair_ok, conflict_cause}, e);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] ucn, ucs, in_n, in_s;
      logic [3:0]  e;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
            checks++;
            if (!out_valid || {pair_ok, conflict_cause} !== e) begin
               failures++;
               $display("FAIL b2b%0d got=%b/%b exp=1/%b", i - 1,
                        out_valid, {pair_ok, conflict_cause}, e);
            end
         end
         ucn  = 32'h1 << $urandom_range(0, 11);
         ucs  = 32'h1 << $urandom_range(0, 11);
         in_n = ins(8'(8'h10 + $urandom_range(0, 1)), 8'h20,
                    8'($urandom_range(0, 3)));
         in_s = ins(8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                    8'($urandom_range(0, 3)));
         drive(ucn, ucs, in_n, in_s, 3'd0);
         exp_q.push_back(model(ucn, ucs, in_n, in_s));
      end
      @(negedge clk);
      in_valid = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if (!out_valid || {pair_ok, conflict_cause} !== e) begin
         failures++;
         $display("FAIL b2b_last got=%b/%b exp=1/%b", out_valid,
                  {pair_ok, conflict_cause}, e);
      end
   endtask

   task automatic test_hold_count;
      logic [2:0] cv[3];
      logic [3:0] e;
      int         n;
      cv = '{3'd1, 3'd2, 3'd7};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
               ins(8'h01, 8'h02, 8'h07), cv[i]);
         exp_q.push_back(4'b1000);
         @(negedge clk);
         in_valid = 1'b0;
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
         checks++;
         if ({pair_ok, conflict_cause} !== e) begin
            failures++;
            $display("FAIL holdcnt%0d_verdict got=%b exp=%b", cv[i],
                     {pair_ok, conflict_cause}, e);
         end
         n = 0;
         for (int k = 0; k < 16; k++) begin
            if (busy !== 1'b1) break;
            n++;
            @(negedge clk);
         end
         checks++;
         if (n != int'(cv[i])) begin
            failures++;
            $display("FAIL holdcnt%0d_busy_cycles got=%0d exp=%0d",
                     cv[i], n, cv[i]);
         end
      end
   endtask

   task automatic test_hold_pairs;
      logic [3:0] e;
      int         n;
      // Pair accepted on the final HOLD cycle is judged as HOLD.
      @(negedge clk);
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd1);
      exp_q.push_back(4'b1000);
      @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if ({pair_ok, conflict_cause} !== e) begin
         failures++;
         $display("FAIL edge_first got=%b exp=%b",
                  {pair_ok, conflict_cause}, e);
      end
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd0);
      exp_q.push_back(4'b0000);
      @(negedge clk);
      in_valid = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if (!out_valid || {pair_ok, conflict_cause} !== e || busy) begin
         failures++;
         $display("FAIL edge_last got=%b/%b busy=%b exp=1/%b busy=0",
                  out_valid, {pair_ok, conflict_cause}, busy, e);
      end
      // cnt=3, with a clean pair (cnt=7) during HOLD that must not reload.
      @(negedge clk);
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd3);
      exp_q.push_back(4'b1000);
      @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if ({pair_ok, conflict_cause} !== e) begin
         failures++;
         $display("FAIL hold_first got=%b exp=%b",
                  {pair_ok, conflict_cause}, e);
      end
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd7);
      exp_q.push_back(4'b0000);
      n = 0;
      for (int k = 0; k < 16; k++) begin
         if (busy !== 1'b1) break;
         n++;
         @(negedge clk);
         if (k == 0) begin
            in_valid = 1'b0;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
            checks++;
            if (!out_valid || {pair_ok, conflict_cause} !== e) begin
               failures++;
               $display("FAIL hold_mid got=%b/%b exp=1/%b", out_valid,
                        {pair_ok, conflict_cause}, e);
            end
         end
      end
      checks++;
      if (n != 3) begin
         failures++;
         $display("FAIL hold_busy_cycles got=%0d exp=3", n);
      end
      @(negedge clk);
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd0);
      exp_q.push_back(4'b1000);
      @(negedge clk);
      in_valid = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if (!out_valid || {pair_ok, conflict_cause} !== e) begin
         failures++;
         $display("FAIL hold_after got=%b/%b exp=1/%b", out_valid,
                  {pair_ok, conflict_cause}, e);
      end
   endtask

   task automatic test_stall;
      logic [3:0] e;
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd0);
      exp_q.push_back(4'b1000);
      @(negedge clk);
      drive(32'h4, 32'h4, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd0);
      for (int k = 0; k < 4; k++) begin
         e = (exp_q.size() != 0) ? exp_q[0] : 4'bxxxx;
         checks++;
         if (!out_valid || {pair_ok, conflict_cause} !== e ||
             in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall%0d got=%b/%b rdy=%b exp=1/%b rdy=0", k,
                     out_valid, {pair_ok, conflict_cause}, in_ready, e);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back(4'b0001);
      @(negedge clk);
      in_valid = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if (!out_valid || {pair_ok, conflict_cause} !== e) begin
         failures++;
         $display("FAIL replace got=%b/%b exp=1/%b", out_valid,
                  {pair_ok, conflict_cause}, e);
      end
   endtask

   task automatic test_reset_hold;
      logic [3:0] e;
      @(negedge clk);
      out_ready = 1'b0;
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd5);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL rsthold_pre busy=%b valid=%b exp=1/1",
                  busy, out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rsthold busy=%b valid=%b rdy=%b exp=0/0/1",
                  busy, out_valid, in_ready);
      end
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      drive(32'h1, 32'h2, ins(8'h33, 8'h44, 8'h05),
            ins(8'h01, 8'h02, 8'h07), 3'd0);
      exp_q.push_back(4'b1000);
      @(negedge clk);
      in_valid = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bxxxx;
      checks++;
      if (!out_valid || {pair_ok, conflict_cause} !== e) begin
         failures++;
         $display("FAIL rsthold_after got=%b/%b exp=1/%b", out_valid,
                  {pair_ok, conflict_cause}, e);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_waw;
      test_back_to_back;
      test_hold_count;
      test_hold_pairs;
      test_stall;
      test_reset_hold;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
